// File: rtl/mutative_mem_arbiter.sv
// Two-requester line memory arbiter (I-cache / D-cache) with a registered grant FSM.
// Define MUTATIVE_ARB_RR_EN for round-robin tie-breaking; default is D-side fixed priority.
module mutative_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  arb_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   arb_err_q, arb_err_d;
  logic   i_req, d_req;
  logic   tie_pick_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

`ifdef MUTATIVE_ARB_RR_EN
  // last_d_q = 1 means the D side held the most recent grant.
  logic last_d_q, last_d_d;

  assign tie_pick_d = ~last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE) begin
      if (state_d == GRANT_D) begin
        last_d_d = 1'b1;
      end else if (state_d == GRANT_I) begin
        last_d_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign tie_pick_d = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    arb_err_d = arb_err_q;
    case (state_q)
      IDLE: begin
        if (mem_resp) begin
          arb_err_d = 1'b1;
        end
        if (i_req && d_req) begin
          state_d = tie_pick_d ? GRANT_D : GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I: begin
        if (i_read && i_write) begin
          arb_err_d = 1'b1;
        end
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        if (d_read && d_write) begin
          arb_err_d = 1'b1;
        end
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_err_q <= arb_err_d;
    end
  end

  // Datapath is purely combinational from the registered owner, so reset zeroes it at once.
  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_resp    = 1'b0;
    d_rdata   = '0;
    d_resp    = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem_addr  = i_addr;
        mem_read  = i_read;
        mem_write = i_write;
        mem_wdata = i_wdata;
        i_rdata   = mem_rdata;
        i_resp    = mem_resp;
      end
      GRANT_D: begin
        mem_addr  = d_addr;
        mem_read  = d_read;
        mem_write = d_write;
        mem_wdata = d_wdata;
        d_rdata   = mem_rdata;
        d_resp    = mem_resp;
      end
      default: ;
    endcase
  end

  assign arb_err = arb_err_q;

endmodule

// File: doc/mutative_mem_arbiter.md
Name: mutative_mem_arbiter

Overview:
- Shares a single line-wide memory port between the instruction-side and data-side mutative caches.
- Each cache's downward-facing port (dfp_*) connects to one requester port.
- Serializes line reads/writes with a registered grant FSM and routes the memory response back to the owner only.
- Sits between the two cache instances and the memory model / burst adapter.

Parameters:
ADDR_WIDTH, 32, line address width
LINE_WIDTH, 256, line data width (one 32-byte cache line)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_addr  input  ADDR_WIDTH  I-cache line address
i_read  input  1  I-cache line read request
i_write  input  1  I-cache line write request
i_wdata  input  LINE_WIDTH  I-cache writeback data
i_rdata  output  LINE_WIDTH  read data to I-cache
i_resp  output  1  completion pulse to I-cache
d_addr  input  ADDR_WIDTH  D-cache line address
d_read  input  1  D-cache line read request
d_write  input  1  D-cache line write request
d_wdata  input  LINE_WIDTH  D-cache writeback data
d_rdata  output  LINE_WIDTH  read data to D-cache
d_resp  output  1  completion pulse to D-cache
mem_addr  output  ADDR_WIDTH  memory line address
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_wdata  output  LINE_WIDTH  memory write data
mem_rdata  input  LINE_WIDTH  memory read data
mem_resp  input  1  memory completion pulse
arb_err  output  1  sticky protocol error flag

Behaviour:
- Requester contract: read/write, addr and wdata held stable from assertion until its resp cycle. Read and write are never both high at once.
- FSM states: IDLE, GRANT_I, GRANT_D. Reset state is IDLE.
- IDLE:
  - Samples requests (req = read|write).
  - Both pending: choose by priority policy (Optional Feature).
  - Only one pending: grant it.
  - None pending: stay in IDLE.
  - Transition occurs at the clock edge. Memory sees the request 1 cycle after the requester asserts it; that arbitration cycle is fixed.
- GRANT_x:
  - mem_addr, mem_read, mem_write and mem_wdata are driven combinationally from the owner's inputs.
  - mem_rdata is routed to owner rdata.
  - On mem_resp: owner resp=1 for that cycle only, and the FSM returns to IDLE.
  - Non-owner resp=0 at all times; non-owner rdata=0.
- IDLE outputs:
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - i_resp=0, d_resp=0.
- A grant is never re-issued in the cycle mem_resp is seen. The minimum gap between back-to-back memory transactions is 1 IDLE cycle.
- D-cache writeback followed by fill is two separate transactions. The fill arbitrates again and may lose to a pending I request.
- mem_resp while in IDLE: ignored, no resp forwarded, arb_err set.
- Owner read and write both high in GRANT_x: forward unchanged, set arb_err.
- Owner drops its request before mem_resp: mem_read/mem_write follow combinationally; arbiter stays in GRANT_x until mem_resp. Memory must not see that case (bench checks).
- arb_err clears only on reset.
- Async reset mid-transaction: FSM returns to IDLE immediately, all outputs go to 0 without waiting for a clock, and the RR pointer resets to "I-side next".

Optional Feature:
- Macro MUTATIVE_ARB_RR_EN.
- Defined: round-robin.
  - 1-bit last-owner register, updated on every grant.
  - On a tie in IDLE, the requester not served last wins.
  - Reset value: D-side last, so I wins the first tie.
- Undefined: fixed priority, D-cache always wins ties; no last-owner register.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Only i_read=1, addr 0x0000_1000, memory resp after 5 cycles with rdata pattern A5…: mem_read rises 1 cycle after i_read; i_resp is 1 for 1 cycle with i_rdata=A5…; d_resp stays 0.
- d_write addr 0x0000_2020 wdata 0x1234…, then d_read addr 0x0000_3000 the cycle after d_resp: two memory transactions in order, 1 IDLE cycle between them, mem_wdata=0x1234… during the write.
- i_read and d_read asserted in the same cycle from reset, repeated 4 times:
  - Fixed build: D,I,D,I order is not required; D always wins the tie.
  - RR build: I,D,I,D.
- rst_n pulled low while in GRANT_D with mem_read high: mem_read=0 and d_resp=0 immediately (before the next edge); state is IDLE after release.
- mem_resp pulsed while IDLE: no resp on either side; arb_err=1 and stays 1 until reset.
- i_read and i_write both high while granted: arb_err=1; mem_read=1 and mem_write=1 forwarded unchanged.
